out_uart_bridge: RTL and testbench



---
 rtl/out_uart_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_out_uart_bridge.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/out_uart_bridge.sv
// out_uart_bridge: watches the CPU OUT register and queues every change in a
// small FIFO. Each queued value is sent as a sequence of 8N1 UART frames on
// UART_TX.
// Optional feature macro: OUT_HEX_ASCII_EN. When it is defined, each value is
// sent as uppercase ASCII hex digits followed by a line feed. When it is not
// defined, each value is sent as raw little-endian bytes.
module out_uart_bridge #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int WTIME = 868
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [DW-1:0] OUT_VALUE,
  output logic          UART_TX,
  output logic          busy,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WTIME);
`ifdef OUT_HEX_ASCII_EN
  localparam int NB = DW / 4 + 1;
`else
  localparam int NB = (DW + 7) / 8;
`endif
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Change detector and FIFO state
  logic [DW-1:0]  r_last;
  logic [DW-1:0]  r_mem [0:DEPTH-1];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           r_overflow;

  // Transmitter state
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [BIW-1:0] r_bidx;
  logic [DW-1:0]  r_word;
  logic [7:0]     r_byte;
  logic           r_tx;
  logic           r_busy;

  logic           w_change;
  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_drop;
  logic           w_pop;
  logic [AW:0]    w_count_nxt;
  logic [DW-1:0]  w_head;
  logic           w_cnt_last;
  state_t         w_state_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [2:0]     w_bit_nxt;
  logic [BIW-1:0] w_bidx_nxt;
  logic [DW-1:0]  w_word_nxt;
  logic [7:0]     w_byte_nxt;
  logic           w_tx_nxt;

  // Returns byte number idx of the transmit sequence for one queued value.
`ifdef OUT_HEX_ASCII_EN
  function automatic logic [7:0] f_byte(input logic [DW-1:0] word,
                                        input logic [BIW-1:0] idx);
    logic [DW-1:0] sh;
    logic [3:0]    nib;
    logic [7:0]    res;
    int            i;
    i   = int'(idx);
    sh  = '0;
    nib = '0;
    res = 8'h0A;
    if (i < DW / 4) begin
      sh  = word >> (4 * (DW / 4 - 1 - i));
      nib = sh[3:0];
      if (nib < 4'd10) res = 8'h30 + {4'h0, nib};
      else             res = 8'h37 + {4'h0, nib};
    end
    return res;
  endfunction
`else
  function automatic logic [7:0] f_byte(input logic [DW-1:0] word,
                                        input logic [BIW-1:0] idx);
    logic [NB*8-1:0] pad;
    pad          = '0;
    pad[DW-1:0]  = word;
    pad          = pad >> (8 * int'(idx));
    return pad[7:0];
  endfunction
`endif

  assign w_change   = (OUT_VALUE != r_last);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_push     = w_change && (!w_full || w_pop);
  assign w_drop     = w_change && w_full && !w_pop;
  assign w_head     = r_mem[r_rptr];
  assign w_cnt_last = (r_cnt == CW'(WTIME - 1));

  // FIFO occupancy after this edge
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Change detection, FIFO pointers/count and sticky overflow flag
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_last     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_change) r_last <= OUT_VALUE;
      if (w_push)   r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      if (w_drop)   r_overflow <= 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge CLOCK) begin
    if (!RESET && w_push) r_mem[r_wptr] <= OUT_VALUE;
  end

  // Transmitter next-state, bit timing, byte sequencing and next line level
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_bidx_nxt  = r_bidx;
    w_word_nxt  = r_word;
    w_byte_nxt  = r_byte;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_word_nxt  = w_head;
          w_bidx_nxt  = '0;
          w_byte_nxt  = f_byte(w_head, '0);
          w_cnt_nxt   = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) w_state_nxt = STOP;
          else               w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          // Next byte of this value first, then the next queued value, so
          // frames stay back-to-back with no idle cycle between them.
          if (r_bidx != BIW'(NB - 1)) begin
            w_bidx_nxt  = r_bidx + 1'b1;
            w_byte_nxt  = f_byte(r_word, r_bidx + 1'b1);
            w_state_nxt = START;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_word_nxt  = w_head;
            w_bidx_nxt  = '0;
            w_byte_nxt  = f_byte(w_head, '0);
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_byte_nxt[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Transmitter registers; the line level and busy are registered outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_bidx  <= '0;
      r_word  <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_bidx  <= w_bidx_nxt;
      r_word  <= w_word_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
    end
  end

  assign UART_TX  = r_tx;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_out_uart_bridge.sv
// Directed bench for out_uart_bridge with DW=8, DEPTH=4, WTIME=4.
// Expected frame contents follow OUT_HEX_ASCII_EN when that macro is defined.
module tb_out_uart_bridge;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int WT    = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] out_value;
  logic          uart_tx;
  logic          busy;
  logic          overflow;

  int n_chk = 0;
  int n_err = 0;

  out_uart_bridge #(.DW(DW), .DEPTH(DEPTH), .WTIME(WT)) dut (
    .CLOCK     (clk),
    .RESET     (rst),
    .OUT_VALUE (out_value),
    .UART_TX   (uart_tx),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'h30; 4'h1: c = 8'h31; 4'h2: c = 8'h32; 4'h3: c = 8'h33;
      4'h4: c = 8'h34; 4'h5: c = 8'h35; 4'h6: c = 8'h36; 4'h7: c = 8'h37;
      4'h8: c = 8'h38; 4'h9: c = 8'h39; 4'hA: c = 8'h41; 4'hB: c = 8'h42;
      4'hC: c = 8'h43; 4'hD: c = 8'h44; 4'hE: c = 8'h45; default: c = 8'h46;
    endcase
    return c;
  endfunction

`ifdef OUT_HEX_ASCII_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 1;
`endif

  function automatic logic [7:0] exp_byte(input logic [7:0] v, input int i);
`ifdef OUT_HEX_ASCII_EN
    if (i == 0)      return hex_char(v[7:4]);
    else if (i == 1) return hex_char(v[3:0]);
    else             return 8'h0A;
`else
    if (i == 0) return v;
    else        return 8'h00;
`endif
  endfunction

  // Check one frame cycle by cycle, starting at cycle 'skip' of the frame.
  task automatic recv(input logic [7:0] b, input int skip);
    for (int idx = skip; idx < 10 * WT; idx++) begin
      int   bt;
      logic e;
      bt = idx / WT;
      if (bt == 0)      e = 1'b0;
      else if (bt == 9) e = 1'b1;
      else              e = b[bt-1];
      chk("tx_bit", {15'd0, uart_tx}, {15'd0, e});
      chk("busy_in_frame", {15'd0, busy}, 16'd1);
      tick();
    end
  endtask

  task automatic expect_frames(input logic [7:0] v, input int skip);
    for (int i = 0; i < NBYTES; i++) recv(exp_byte(v, i), (i == 0) ? skip : 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, {15'd0, uart_tx}, 16'd1);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
  endtask

  task automatic send(input logic [7:0] v);
    out_value = v;
    tick();
    chk("push_edge_tx", {15'd0, uart_tx}, 16'd1);
    chk("push_edge_busy", {15'd0, busy}, 16'd1);
    tick();
    expect_frames(v, 0);
    chk_idle("after_frames");
  endtask

  logic [7:0] ov_vals [0:5];
  logic [7:0] wrap_vals [0:11];

  initial begin
    ov_vals   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    wrap_vals = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5,
                  8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h7E, 8'h81};
    rst       = 1'b1;
    out_value = '0;

    // Reset state
    tick(); tick(); tick();
    chk_idle("reset");
    chk("reset_ovf", {15'd0, overflow}, 16'd0);
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Single frame for 0x67
    send(8'h67);

    // Holding the same value must produce nothing
    for (int i = 0; i < 200; i++) begin
      tick();
      chk_idle("hold");
    end

    // Overflow: six changes on consecutive edges into a 4-entry FIFO
    for (int i = 0; i < 6; i++) begin
      out_value = ov_vals[i];
      tick();
      chk("ovf_flag", {15'd0, overflow}, (i == 5) ? 16'd1 : 16'd0);
      if (i >= 1 && i <= 4) chk("ovf_start_bit", {15'd0, uart_tx}, 16'd0);
    end
    expect_frames(ov_vals[0], 4);
    for (int i = 1; i < 5; i++) expect_frames(ov_vals[i], 0);
    chk_idle("ovf_drained");
    chk("ovf_sticky", {15'd0, overflow}, 16'd1);
    for (int i = 0; i < 20; i++) tick();
    chk_idle("ovf_no_f");

    // Reset in the middle of a data bit
    out_value = 8'h3C;
    tick();
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("mid_frame_busy", {15'd0, busy}, 16'd1);
    rst       = 1'b1;
    out_value = 8'h12;
    tick();
    chk_idle("mid_reset");
    chk("mid_reset_ovf", {15'd0, overflow}, 16'd0);
    rst = 1'b0;
    tick();
    chk("release_tx", {15'd0, uart_tx}, 16'd1);
    chk("release_busy", {15'd0, busy}, 16'd1);
    tick();
    expect_frames(8'h12, 0);
    chk_idle("after_reset_frame");

    // Pointer wrap-around with spaced changes
    for (int i = 0; i < 12; i++) send(wrap_vals[i]);
    chk("wrap_ovf", {15'd0, overflow}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
